// File: rtl/flash_pkg.sv
// Shared definitions for the SPI flash boot path: loader state encoding,
// flash command opcodes and the image header length width.
package flash_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE,
        LDR_LEN_HI,
        LDR_LEN_LO,
        LDR_DATA,
        LDR_CSUM,
        LDR_DONE,
        LDR_ERR
    } ldr_state_e;

    localparam logic [7:0] SPI_CMD_RDSR = 8'h05;
    localparam logic [7:0] SPI_CMD_READ = 8'h03;

    localparam int LEN_W = 16;

endpackage

// File: rtl/flash_copy_loader_byte_word_packer.sv
// Packs payload bytes little-endian into RAM words; a completed word is
// parked in the output register until the loader's write strobe retires it.
module byte_word_packer #(
    parameter int WORD_BYTES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear_i,
    input  logic                    accept_i,
    input  logic [7:0]              byte_i,
    input  logic [15:0]             count_i,
    input  logic                    last_i,
    input  logic                    write_i,
    output logic                    word_full_o,
    output logic [8*WORD_BYTES-1:0] wdata_o
);

    logic [8*WORD_BYTES-1:0] acc_q, acc_d;
    logic [8*WORD_BYTES-1:0] wdata_q, wdata_d;
    logic [8*WORD_BYTES-1:0] merged;
    logic                    full_q, full_d;
    int unsigned             lane;

    always_comb begin
        acc_d   = acc_q;
        wdata_d = wdata_q;
        full_d  = full_q;
        lane    = 32'(count_i % 16'(WORD_BYTES));
        merged  = acc_q;
        merged[lane*8 +: 8] = byte_i;
        if (clear_i) begin
            acc_d   = '0;
            wdata_d = '0;
            full_d  = 1'b0;
        end else begin
            if (write_i) begin
                full_d = 1'b0;
            end
            // Accumulator lanes above the current one are still zero, which
            // gives the zero fill of a short final word for free.
            if (accept_i) begin
                if (lane == 32'(WORD_BYTES - 1) || last_i) begin
                    wdata_d = merged;
                    acc_d   = '0;
                    full_d  = 1'b1;
                end else begin
                    acc_d = merged;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q   <= '0;
            wdata_q <= '0;
            full_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            wdata_q <= wdata_d;
            full_q  <= full_d;
        end
    end

    assign word_full_o = full_q;
    assign wdata_o     = wdata_q;

endmodule

// File: rtl/flash_copy_loader.sv
// Boot image copy loader: parses length header and payload from the flash
// byte stream into RAM. Optional trailing XOR checksum: FLASH_COPY_LOADER_CHECKSUM_EN.
module flash_copy_loader
    import flash_pkg::*;
#(
    parameter int ADDR_W     = 12,
    parameter int WORD_BYTES = 2,
    parameter int MAX_BYTES  = 8192
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [8*WORD_BYTES-1:0] mem_wdata,
    output logic                    mem_we,
    input  logic                    mem_busy,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [15:0]             byte_count
);

`ifdef FLASH_COPY_LOADER_CHECKSUM_EN
    localparam ldr_state_e POST_DATA = LDR_CSUM;
    logic [7:0] xor_q, xor_d;
`else
    localparam ldr_state_e POST_DATA = LDR_DONE;
`endif

    ldr_state_e        state_q, state_d;
    logic [7:0]        len_hi_q, len_hi_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_full;
    logic              clear, data_accept, last_byte, we, word_full;

    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
`ifdef FLASH_COPY_LOADER_CHECKSUM_EN
        xor_d       = xor_q;
`endif
        in_ready    = 1'b0;
        we          = 1'b0;
        clear       = 1'b0;
        data_accept = 1'b0;
        last_byte   = 1'b0;
        len_full    = {len_hi_q, in_data};

        case (state_q)
            LDR_IDLE, LDR_DONE, LDR_ERR: begin
                if (start) begin
                    clear   = 1'b1;
                    cnt_d   = '0;
                    addr_d  = '0;
`ifdef FLASH_COPY_LOADER_CHECKSUM_EN
                    xor_d   = '0;
`endif
                    state_d = LDR_LEN_HI;
                end
            end
            LDR_LEN_HI: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    len_hi_d = in_data;
                    state_d  = LDR_LEN_LO;
                end
            end
            LDR_LEN_LO: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    len_d = len_full;
                    if (32'(len_full) > MAX_BYTES) begin
                        state_d = LDR_ERR;
                    end else if (len_full == '0) begin
                        state_d = POST_DATA;
                    end else begin
                        state_d = LDR_DATA;
                    end
                end
            end
            LDR_DATA: begin
                // Stop taking bytes once the payload is complete so the count
                // saturates at len while the last word drains.
                in_ready = (cnt_q != len_q) && !(word_full && mem_busy);
                we       = word_full && !mem_busy;
                if (we) begin
                    addr_d = addr_q + 1'b1;
                end
                if (in_ready && in_valid) begin
                    data_accept = 1'b1;
                    cnt_d       = cnt_q + 1'b1;
                    last_byte   = (cnt_q + 1'b1 == len_q);
`ifdef FLASH_COPY_LOADER_CHECKSUM_EN
                    xor_d       = xor_q ^ in_data;
`endif
                end
                if (we && cnt_q == len_q) begin
                    state_d = POST_DATA;
                end
            end
`ifdef FLASH_COPY_LOADER_CHECKSUM_EN
            LDR_CSUM: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = (in_data == xor_q) ? LDR_DONE : LDR_ERR;
                end
            end
`endif
            default: state_d = LDR_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= LDR_IDLE;
            len_hi_q <= '0;
            len_q    <= '0;
            cnt_q    <= '0;
            addr_q   <= '0;
`ifdef FLASH_COPY_LOADER_CHECKSUM_EN
            xor_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            len_hi_q <= len_hi_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
`ifdef FLASH_COPY_LOADER_CHECKSUM_EN
            xor_q    <= xor_d;
`endif
        end
    end

    byte_word_packer #(
        .WORD_BYTES(WORD_BYTES)
    ) u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear_i    (clear),
        .accept_i   (data_accept),
        .byte_i     (in_data),
        .count_i    (cnt_q),
        .last_i     (last_byte),
        .write_i    (we),
        .word_full_o(word_full),
        .wdata_o    (mem_wdata)
    );

    assign mem_we     = we;
    assign mem_addr   = addr_q;
    assign byte_count = cnt_q;
    assign busy       = (state_q == LDR_LEN_HI) || (state_q == LDR_LEN_LO) ||
                        (state_q == LDR_DATA)   || (state_q == LDR_CSUM);
    assign done       = (state_q == LDR_DONE);
    assign error      = (state_q == LDR_ERR);

endmodule

// File: tb/tb_flash_copy_loader.sv
// Directed self-checking bench for flash_copy_loader (default parameters).
module tb_flash_copy_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_busy;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] byte_count;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned timeouts = 0;
    int unsigned we_busy_viol = 0;
    logic [11:0] wq_addr[$];
    logic [15:0] wq_data[$];

    flash_copy_loader #(
        .ADDR_W    (12),
        .WORD_BYTES(2),
        .MAX_BYTES (8192)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_busy  (mem_busy),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .byte_count(byte_count)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled mid-cycle where combinational strobes are stable.
    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            wq_addr.push_back(mem_addr);
            wq_data.push_back(mem_wdata);
            if (mem_busy) we_busy_viol++;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd0);
        check_eq({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check_eq({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check_eq({tag, "_mem_we"}, 32'(mem_we), 32'd0);
        check_eq({tag, "_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
        check_eq({tag, "_error"}, 32'(error), 32'd0);
        check_eq({tag, "_byte_count"}, 32'(byte_count), 32'd0);
    endtask

    task automatic check_write(input string tag, input int unsigned idx,
                               input logic [11:0] addr, input logic [15:0] data);
        if (wq_addr.size() > idx) begin
            check_eq({tag, "_addr"}, 32'(wq_addr[idx]), 32'(addr));
            check_eq({tag, "_data"}, 32'(wq_data[idx]), 32'(data));
        end else begin
            check_eq({tag, "_missing"}, 32'(wq_addr.size()), idx + 1);
        end
    endtask

    task automatic clear_writes();
        wq_addr.delete();
        wq_data.delete();
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int unsigned n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) timeouts++;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic send_image(input byte_q_t img);
        foreach (img[i]) send_byte(img[i]);
    endtask

    task automatic wait_end();
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!(done || error) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!(done || error)) timeouts++;
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_data  = 8'h00;
        in_valid = 1'b0;
        mem_busy = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Four-byte payload, two full words.
        clear_writes();
        pulse_start();
        check_eq("t1_busy", 32'(busy), 32'd1);
        check_eq("t1_in_ready", 32'(in_ready), 32'd1);
        send_image('{8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44});
        wait_end();
        check_eq("t1_done", 32'(done), 32'd1);
        check_eq("t1_error", 32'(error), 32'd0);
        check_eq("t1_count", 32'(byte_count), 32'd4);
        check_eq("t1_nwr", 32'(wq_addr.size()), 32'd2);
        check_write("t1_w0", 0, 12'd0, 16'h2211);
        check_write("t1_w1", 1, 12'd1, 16'h4433);
        check_eq("t1_busy_end", 32'(busy), 32'd0);
        check_eq("t1_ready_end", 32'(in_ready), 32'd0);
        check_eq("t1_addr_end", 32'(mem_addr), 32'd2);

        // Odd length: final word zero-filled in the upper lane.
        clear_writes();
        pulse_start();
        check_eq("t2_done_clr", 32'(done), 32'd0);
        send_image('{8'h00, 8'h03, 8'hAA, 8'hBB, 8'hCC});
        wait_end();
        check_eq("t2_done", 32'(done), 32'd1);
        check_eq("t2_count", 32'(byte_count), 32'd3);
        check_eq("t2_nwr", 32'(wq_addr.size()), 32'd2);
        check_write("t2_w0", 0, 12'd0, 16'hBBAA);
        check_write("t2_w1", 1, 12'd1, 16'h00CC);

`ifdef FLASH_COPY_LOADER_CHECKSUM_EN
        // 01^02^03^04 = 04
        clear_writes();
        pulse_start();
        send_image('{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04});
        wait_end();
        check_eq("cs_ok_done", 32'(done), 32'd1);
        check_eq("cs_ok_error", 32'(error), 32'd0);
        check_write("cs_ok_w1", 1, 12'd1, 16'h0403);
        pulse_start();
        send_image('{8'h00, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        wait_end();
        check_eq("cs_bad_done", 32'(done), 32'd0);
        check_eq("cs_bad_error", 32'(error), 32'd1);
        clear_writes();
        pulse_start();
        send_image('{8'h00, 8'h00, 8'h00});
        wait_end();
        check_eq("z_done", 32'(done), 32'd1);
        check_eq("z_nwr", 32'(wq_addr.size()), 32'd0);
`else
        clear_writes();
        pulse_start();
        send_image('{8'h00, 8'h00});
        wait_end();
        check_eq("z_done", 32'(done), 32'd1);
        check_eq("z_count", 32'(byte_count), 32'd0);
        check_eq("z_nwr", 32'(wq_addr.size()), 32'd0);
`endif

        // Oversize length header.
        clear_writes();
        pulse_start();
        send_image('{8'h40, 8'h00});
        check_eq("ovf_error", 32'(error), 32'd1);
        check_eq("ovf_done", 32'(done), 32'd0);
        check_eq("ovf_busy", 32'(busy), 32'd0);
        check_eq("ovf_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b1;
        in_data  = 8'h5A;
        repeat (5) @(negedge clk);
        check_eq("ovf_ready_late", 32'(in_ready), 32'd0);
        check_eq("ovf_nwr", 32'(wq_addr.size()), 32'd0);
        check_eq("ovf_count", 32'(byte_count), 32'd0);
        @(posedge clk);
        #1 in_valid = 1'b0;

        // RAM busy as the first word completes.
        clear_writes();
        pulse_start();
        send_image('{8'h00, 8'h04, 8'h11});
        mem_busy = 1'b1;
        send_byte(8'h22);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq($sformatf("stall%0d_ready", i), 32'(in_ready), 32'd0);
            check_eq($sformatf("stall%0d_we", i), 32'(mem_we), 32'd0);
        end
        @(posedge clk);
        #1 mem_busy = 1'b0;
        @(negedge clk);
        check_eq("stall_rel_we", 32'(mem_we), 32'd1);
        check_eq("stall_rel_addr", 32'(mem_addr), 32'd0);
        check_eq("stall_rel_data", 32'(mem_wdata), 32'h2211);
        @(posedge clk);
        #1;
        send_image('{8'h33, 8'h44});
        wait_end();
        check_eq("stall_done", 32'(done), 32'd1);
        check_eq("stall_nwr", 32'(wq_addr.size()), 32'd2);
        check_write("stall_w0", 0, 12'd0, 16'h2211);
        check_write("stall_w1", 1, 12'd1, 16'h4433);

        // Reset in the middle of a load, then reload.
        clear_writes();
        pulse_start();
        send_image('{8'h00, 8'h08, 8'h01, 8'h02, 8'h03});
        rst_n = 1'b0;
        #1;
        check_reset("midrst");
        clear_writes();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midrst_nwr", 32'(wq_addr.size()), 32'd0);
        pulse_start();
        send_image('{8'h00, 8'h02, 8'h55, 8'h66});
        wait_end();
        check_eq("reload_done", 32'(done), 32'd1);
        check_eq("reload_count", 32'(byte_count), 32'd2);
        check_eq("reload_nwr", 32'(wq_addr.size()), 32'd1);
        check_write("reload_w0", 0, 12'd0, 16'h6655);

        check_eq("timeouts", timeouts, 32'd0);
        check_eq("we_while_busy", we_busy_viol, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
